// File: rtl/bcd_conv_sched_if.sv
// Client-side bundle of the shared binary-to-BCD converter: requests, packed operands,
// per-client ack/done pulses and the BCD result digits.
interface bcd_conv_sched_if #(
    parameter int NREQ = 3,
    parameter int W    = 12
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] bin_in;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [2:0]        grant_id;
    logic              busy;
    logic [3:0]        tho, hun, ten, one;

    modport master (output req, bin_in,
                    input  ack, done, grant_id, busy, tho, hun, ten, one);
    modport slave  (input  req, bin_in,
                    output ack, done, grant_id, busy, tho, hun, ten, one);
endinterface

// File: rtl/bcd_conv_sched.sv
// One double-dabble engine shared by NREQ clients, one operand bit per clock.
// Define BCD_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module bcd_dabble_digit (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_conv_sched #(
    parameter int NREQ = 3,
    parameter int W    = 12
) (
    input logic            clk,
    input logic            rst,
    bcd_conv_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_n;
    logic [W-1:0]    sh, sh_n, opnd;
    logic [3:0][3:0] dig, adj, dig_n, res;
    logic [3:0]      cnt;
    logic [NREQ-1:0] ack_q, done_q;
    logic [2:0]      gid, win_idx;
    logic            win_vld;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dig
            bcd_dabble_digit u_adj (.d(dig[g]), .q(adj[g]));
        end
    endgenerate

    // add-3 correction first, then one left shift of {digits, operand}
    assign {dig_n, sh_n} = {adj, sh} << 1;

`ifdef BCD_SCHED_RR_EN
    logic [2:0] ptr;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++)
            for (int i = 0; i < NREQ; i++)
                if (!win_vld && bus.req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    win_vld = 1'b1;
                    win_idx = 3'(i);
                end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst)                        ptr <= 3'(NREQ - 1);
        else if (state == IDLE && win_vld) ptr <= win_idx;
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (bus.req[i]) begin
                win_vld = 1'b1;
                win_idx = 3'(i);
            end
    end
`endif

    always_comb begin
        opnd = '0;
        for (int i = 0; i < NREQ; i++)
            if (win_idx == 3'(i)) opnd = bus.bin_in[i*W +: W];
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (win_vld) state_n = SHIFT;
            SHIFT:   if (cnt == 4'd0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh     <= '0;
            dig    <= '0;
            cnt    <= '0;
            ack_q  <= '0;
            done_q <= '0;
            gid    <= '0;
            res    <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state)
                IDLE: if (win_vld) begin
                    sh  <= opnd;
                    dig <= '0;
                    cnt <= 4'(W - 1);
                    gid <= win_idx;
                    for (int i = 0; i < NREQ; i++) ack_q[i] <= (win_idx == 3'(i));
                end
                SHIFT: begin
                    dig <= dig_n;
                    sh  <= sh_n;
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                DONE: begin
                    res <= dig;
                    for (int i = 0; i < NREQ; i++) done_q[i] <= (gid == 3'(i));
                end
                default: ;
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.grant_id = gid;
    assign bus.busy     = (state != IDLE);
    assign bus.tho      = res[3];
    assign bus.hun      = res[2];
    assign bus.ten      = res[1];
    assign bus.one      = res[0];
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed and exhaustive checks of bcd_conv_sched with a result scoreboard (NREQ=3, W=12).
module tb_bcd_conv_sched;
    localparam int NREQ = 3;
    localparam int W    = 12;

    typedef struct packed {
        logic [2:0]  c;
        logic [15:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];

    bcd_conv_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    bcd_conv_sched #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer plus per-cycle pulse legality
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
            chk("done_onehot0", 32'($onehot0(bus.done)), 32'd1);
            chk("ack_done_excl", 32'(bus.ack & bus.done), 32'd0);
            if (|bus.done) begin
                if (sb_q.size() == 0) chk("unexpected_done", 32'(bus.done), 32'd0);
                else begin
                    e = sb_q.pop_front();
                    chk("done_client", 32'(bus.done), 32'(1 << e.c));
                    chk("digits", {16'd0, bus.tho, bus.hun, bus.ten, bus.one}, {16'd0, e.d});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input int c, input string tag);
        int n = 0;
        while (!bus.ack[c] && n < 40) begin @(negedge clk); n++; end
        chk(tag, 32'(bus.ack[c]), 32'd1);
    endtask

    task automatic wait_done(input int c, input string tag, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.done[c] && lat < 40);
        chk(tag, 32'(bus.done[c]), 32'd1);
    endtask

    task automatic convert(input int c, input int v);
        int lat;
        bus.bin_in[c*W +: W] = W'(v);
        bus.req[c] = 1'b1;
        sb_q.push_back('{c: 3'(c), d: ref_bcd(v)});
        wait_ack(c, "ack_seen");
        bus.req[c] = 1'b0;
        wait_done(c, "done_seen", lat);
        chk("latency", 32'(lat), 32'(W + 1));
    endtask

    initial begin
        int eo[3];
        int t_prev, lat, ack2_seen;
        bus.req = '0;
        bus.bin_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);
        chk("rst_digits", {16'd0, bus.tho, bus.hun, bus.ten, bus.one}, 32'd0);

        // single conversions incl. max and zero operands
        convert(0, 4095);
        convert(1, 0);
        convert(1, 9);
        convert(1, 1000);
        convert(2, 4094);

        // all clients held: arbitration order and ack spacing
        do_reset();
`ifdef BCD_SCHED_RR_EN
        eo = '{0, 1, 2};
`else
        eo = '{0, 0, 0};
`endif
        bus.bin_in = {12'd300, 12'd200, 12'd100};
        bus.req = 3'b111;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            while (!(|bus.ack) && n < 40) begin @(negedge clk); n++; end
            chk("rr_ack", 32'(bus.ack), 32'(1 << eo[k]));
            chk("rr_gid", 32'(bus.grant_id), 32'(eo[k]));
            chk("rr_busy", 32'(bus.busy), 32'd1);
            sb_q.push_back('{c: 3'(eo[k]), d: ref_bcd((eo[k] + 1) * 100)});
            if (k > 0) chk("rr_spacing", 32'(cyc - t_prev), 32'(W + 2));
            t_prev = cyc;
            if (k == 2) bus.req = '0;
            else @(negedge clk);
        end
        wait_done(eo[2], "rr_last_done", lat);

        // reset during the 5th SHIFT cycle of 1234
        bus.bin_in[0 +: W] = 12'd1234;
        bus.req[0] = 1'b1;
        wait_ack(0, "abort_ack");
        bus.req[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ack0", 32'(bus.ack), 32'd0);
        chk("abort_done0", 32'(bus.done), 32'd0);
        chk("abort_gid", 32'(bus.grant_id), 32'd0);
        chk("abort_digits", {16'd0, bus.tho, bus.hun, bus.ten, bus.one}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(sb_q.size()), 32'd0);
        convert(0, 59);

        // req[2] pulsed only while busy is never granted
        bus.bin_in[0 +: W] = 12'd77;
        bus.req[0] = 1'b1;
        sb_q.push_back('{c: 3'd0, d: ref_bcd(77)});
        wait_ack(0, "pulse_ack0");
        bus.req[0] = 1'b0;
        ack2_seen = 0;
        @(negedge clk);
        bus.bin_in[2*W +: W] = 12'd5;
        bus.req[2] = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.ack[2]) ack2_seen++; end
        bus.req[2] = 1'b0;
        lat = 0;
        while (!bus.done[0] && lat < 40) begin
            @(negedge clk); lat++;
            if (bus.ack[2]) ack2_seen++;
        end
        chk("pulse_done0", 32'(bus.done[0]), 32'd1);
        repeat (5) begin @(negedge clk); if (bus.ack[2]) ack2_seen++; end
        chk("pulse_no_ack2", 32'(ack2_seen), 32'd0);

        // exhaustive sweep against the reference model
        for (int v = 0; v < 4096; v++) convert(v % NREQ, v);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
